// File: rtl/upower_pkg.sv
// Shared uPower definitions: opcode constants, instruction formats,
// fetch/decode FSM states and the zero-masked decoded-field bundle.
package upower_pkg;

  // Primary opcodes (instr[31:26]).
  localparam logic [5:0] OP_XO31   = 6'd31;
  localparam logic [5:0] OP_B      = 6'd19;
  localparam logic [5:0] OP_I      = 6'd18;
  localparam logic [5:0] OP_LD     = 6'd58;
  localparam logic [5:0] OP_STD    = 6'd62;

  // D-form opcodes.
  localparam logic [5:0] OP_ADDI   = 6'd14;
  localparam logic [5:0] OP_ADDIS  = 6'd15;
  localparam logic [5:0] OP_ANDI   = 6'd28;
  localparam logic [5:0] OP_ORI    = 6'd24;
  localparam logic [5:0] OP_XORI   = 6'd26;
  localparam logic [5:0] OP_LWZ    = 6'd32;
  localparam logic [5:0] OP_LBZ    = 6'd34;
  localparam logic [5:0] OP_STW    = 6'd36;
  localparam logic [5:0] OP_STWU   = 6'd37;
  localparam logic [5:0] OP_STB    = 6'd38;
  localparam logic [5:0] OP_LHZ    = 6'd40;
  localparam logic [5:0] OP_LHA    = 6'd42;
  localparam logic [5:0] OP_STH    = 6'd44;

  // XO-form extended opcodes (instr[9:1]) under primary opcode 31.
  localparam logic [8:0] XO_ADD    = 9'd266;
  localparam logic [8:0] XO_SUBF   = 9'd40;

  typedef enum logic [2:0] {
    FMT_XO  = 3'd0,
    FMT_X   = 3'd1,
    FMT_B   = 3'd2,
    FMT_I   = 3'd3,
    FMT_D   = 3'd4,
    FMT_DS  = 3'd5,
    FMT_ILL = 3'd6
  } fmt_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    REQ      = 3'd1,
    WAIT_RSP = 3'd2,
    OUT      = 3'd3,
    WAIT_BR  = 3'd4,
    HALT     = 3'd5
  } state_e;

  // Fields presented to the ALU; anything outside the decoded format is zero.
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [4:0]  bo;
    logic [4:0]  bi;
    logic [15:0] si;
    logic [13:0] ds;
    logic [1:0]  xods;
    logic [9:0]  xox;
    logic [8:0]  xoxo;
    logic        aa;
  } fields_t;

  function automatic logic is_d_form(input logic [5:0] op);
    logic hit;
    case (op)
      OP_ADDI, OP_ADDIS, OP_ANDI, OP_ORI, OP_XORI, OP_LWZ, OP_LBZ,
      OP_STW, OP_STWU, OP_STB, OP_LHZ, OP_LHA, OP_STH: hit = 1'b1;
      default:                                         hit = 1'b0;
    endcase
    return hit;
  endfunction

  // I-form displacement: sext(LI || 0b00).
  function automatic logic [63:0] sext_li(input logic [23:0] li);
    return {{38{li[23]}}, li, 2'b00};
  endfunction

  // B-form displacement: sext(BD || 0b00).
  function automatic logic [63:0] sext_bd(input logic [13:0] bd);
    return {{48{bd[13]}}, bd, 2'b00};
  endfunction

endpackage

// File: rtl/instr_field_split.sv
// Combinational classifier: maps a 32-bit instruction word to its format
// and the field bundle, zeroing every field the format does not own.
module instr_field_split
  import upower_pkg::*;
(
  input  logic [31:0] instr,
  output fmt_e        fmt,
  output fields_t     fields
);

  // Classify the opcode and populate only the fields of that format.
  always_comb begin
    fmt           = FMT_ILL;
    fields        = '0;
    fields.opcode = instr[31:26];
    fields.rd     = instr[25:21];
    fields.ra     = instr[20:16];
    fields.rb     = instr[15:11];
    case (instr[31:26])
      OP_XO31: begin
        if ((instr[9:1] == XO_ADD) || (instr[9:1] == XO_SUBF)) begin
          fmt         = FMT_XO;
          fields.xoxo = instr[9:1];
        end else begin
          fmt         = FMT_X;
          fields.xox  = instr[10:1];
        end
      end
      OP_B: begin
        fmt       = FMT_B;
        fields.bo = instr[25:21];
        fields.bi = instr[20:16];
        fields.aa = instr[1];
      end
      OP_I: begin
        fmt       = FMT_I;
        fields.aa = instr[1];
      end
      OP_LD, OP_STD: begin
        fmt         = FMT_DS;
        fields.ds   = instr[15:2];
        fields.xods = instr[1:0];
      end
      default: begin
        if (is_d_form(instr[31:26])) begin
          fmt       = FMT_D;
          fields.si = instr[15:0];
        end else begin
          fmt       = FMT_ILL;
        end
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// uPower front end: single-outstanding instruction fetch, field decode,
// and PC update for sequential flow, I-form jumps and resolved B-form branches.
module instr_fetch_decode
  import upower_pkg::*;
#(
  parameter logic [63:0] RESET_PC = 64'h0
)
(
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [5:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  ra,
  output logic [4:0]  rb,
  output logic [4:0]  bo,
  output logic [4:0]  bi,
  output logic [15:0] si,
  output logic [13:0] ds,
  output logic [1:0]  xods,
  output logic [9:0]  xox,
  output logic [8:0]  xoxo,
  output logic        aa,
  output logic [63:0] dec_pc,
  input  logic        br_valid,
  input  logic        br_taken,
  output logic        illegal
);

  state_e      state_r;
  state_e      state_next_s;
  logic [63:0] pc_r;
  logic [63:0] pc_next_s;
  logic [63:0] pc_plus4_s;
  logic [63:0] target_r;
  logic [63:0] rsp_target_s;
  fmt_e        fmt_r;
  fmt_e        rsp_fmt_s;
  fields_t     fields_r;
  fields_t     rsp_fields_s;
  logic [63:0] dec_pc_r;
  logic        illegal_r;
  logic        req_valid_r;
  logic        dec_valid_r;
  logic        rsp_take_s;

  instr_field_split u_split (
    .instr  (imem_rsp_data),
    .fmt    (rsp_fmt_s),
    .fields (rsp_fields_s)
  );

  assign pc_plus4_s = pc_r + 64'd4;

  // Branch target of the word on the response bus, relative to the PC that fetched it.
  always_comb begin
    rsp_target_s = pc_plus4_s;
    case (rsp_fmt_s)
      FMT_I: begin
        if (imem_rsp_data[1]) begin
          rsp_target_s = sext_li(imem_rsp_data[25:2]);
        end else begin
          rsp_target_s = pc_r + sext_li(imem_rsp_data[25:2]);
        end
      end
      FMT_B:   rsp_target_s = pc_r + sext_bd(imem_rsp_data[15:2]);
      default: rsp_target_s = pc_plus4_s;
    endcase
  end

  // Next-state and next-PC logic; stray responses and resolutions are ignored by construction.
  always_comb begin
    state_next_s = state_r;
    pc_next_s    = pc_r;
    rsp_take_s   = 1'b0;
    case (state_r)
      IDLE: state_next_s = REQ;
      REQ: begin
        if (imem_req_ready) begin
          state_next_s = WAIT_RSP;
        end else begin
          state_next_s = REQ;
        end
      end
      WAIT_RSP: begin
        if (imem_rsp_valid) begin
          rsp_take_s = 1'b1;
          if (rsp_fmt_s == FMT_ILL) begin
            state_next_s = HALT;
          end else begin
            state_next_s = OUT;
          end
        end else begin
          state_next_s = WAIT_RSP;
        end
      end
      OUT: begin
        if (dec_ready) begin
          case (fmt_r)
            FMT_I: begin
              pc_next_s    = target_r;
              state_next_s = REQ;
            end
            FMT_B: state_next_s = WAIT_BR;
            default: begin
              pc_next_s    = pc_plus4_s;
              state_next_s = REQ;
            end
          endcase
        end else begin
          state_next_s = OUT;
        end
      end
      WAIT_BR: begin
        if (br_valid) begin
          pc_next_s    = br_taken ? target_r : pc_plus4_s;
          state_next_s = REQ;
        end else begin
          state_next_s = WAIT_BR;
        end
      end
      HALT:    state_next_s = HALT;
      default: state_next_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // PC and registered handshake flags, derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_r        <= RESET_PC;
      req_valid_r <= 1'b0;
      dec_valid_r <= 1'b0;
    end else begin
      pc_r        <= pc_next_s;
      req_valid_r <= (state_next_s == REQ);
      dec_valid_r <= (state_next_s == OUT);
    end
  end

  // Capture decoded fields on an accepted response; an illegal word blanks them and halts.
  always_ff @(posedge clk) begin
    if (rst) begin
      fields_r  <= '0;
      fmt_r     <= FMT_ILL;
      target_r  <= 64'd0;
      dec_pc_r  <= 64'd0;
      illegal_r <= 1'b0;
    end else if (rsp_take_s) begin
      if (rsp_fmt_s == FMT_ILL) begin
        fields_r  <= '0;
        dec_pc_r  <= 64'd0;
        illegal_r <= 1'b1;
      end else begin
        fields_r  <= rsp_fields_s;
        fmt_r     <= rsp_fmt_s;
        target_r  <= rsp_target_s;
        dec_pc_r  <= pc_r;
      end
    end
  end

  assign imem_req_valid = req_valid_r;
  assign imem_addr      = pc_r;
  assign dec_valid      = dec_valid_r;
  assign opcode         = fields_r.opcode;
  assign rd             = fields_r.rd;
  assign ra             = fields_r.ra;
  assign rb             = fields_r.rb;
  assign bo             = fields_r.bo;
  assign bi             = fields_r.bi;
  assign si             = fields_r.si;
  assign ds             = fields_r.ds;
  assign xods           = fields_r.xods;
  assign xox            = fields_r.xox;
  assign xoxo           = fields_r.xoxo;
  assign aa             = fields_r.aa;
  assign dec_pc         = dec_pc_r;
  assign illegal        = illegal_r;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Self-checking bench for instr_fetch_decode: a scripted instruction memory
// serves words, expected decodes go to a scoreboard and are compared on handshake.
module tb_instr_fetch_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        dec_valid;
  logic        dec_ready;
  logic [5:0]  opcode;
  logic [4:0]  rd, ra, rb, bo, bi;
  logic [15:0] si;
  logic [13:0] ds;
  logic [1:0]  xods;
  logic [9:0]  xox;
  logic [8:0]  xoxo;
  logic        aa;
  logic [63:0] dec_pc;
  logic        br_valid;
  logic        br_taken;
  logic        illegal;

  logic [146:0] obs;
  logic [146:0] sb_q[$];
  int checks = 0;
  int errors = 0;

  localparam logic [31:0] FMT_WORDS [6] = '{32'h7C642A14, 32'h7C642838, 32'h38610064,
                                            32'h7C221850, 32'hE8A60009, 32'hF8A60010};
  localparam logic [31:0] BR_WORDS [6]  = '{32'h48000202, 32'h48000008, 32'h4BFFFDF8,
                                            32'h4BFFFFFC, 32'h38610064, 32'h48000302};
  localparam logic [63:0] BR_PCS [6]    = '{64'h118, 64'h200, 64'h208,
                                            64'h0, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0};

  always #5 clk = ~clk;

  instr_fetch_decode #(.RESET_PC(64'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .dec_valid(dec_valid), .dec_ready(dec_ready),
    .opcode(opcode), .rd(rd), .ra(ra), .rb(rb), .bo(bo), .bi(bi), .si(si), .ds(ds),
    .xods(xods), .xox(xox), .xoxo(xoxo), .aa(aa), .dec_pc(dec_pc),
    .br_valid(br_valid), .br_taken(br_taken), .illegal(illegal)
  );

  assign obs = {opcode, rd, ra, rb, bo, bi, si, ds, xods, xox, xoxo, aa, dec_pc};

  // Reference decode written from the instruction-format definitions.
  function automatic logic [146:0] ref_decode(input logic [31:0] w, input logic [63:0] pc);
    logic [5:0] op;
    logic [4:0] r_bo, r_bi;
    logic [15:0] r_si;
    logic [13:0] r_ds;
    logic [1:0] r_xods;
    logic [9:0] r_xox;
    logic [8:0] r_xoxo;
    logic r_aa;
    op = w[31:26];
    r_bo = 5'd0; r_bi = 5'd0; r_si = 16'd0; r_ds = 14'd0;
    r_xods = 2'd0; r_xox = 10'd0; r_xoxo = 9'd0; r_aa = 1'b0;
    if (op == 6'd31) begin
      if (w[9:1] == 9'd266 || w[9:1] == 9'd40) r_xoxo = w[9:1];
      else r_xox = w[10:1];
    end else if (op == 6'd19) begin
      r_bo = w[25:21]; r_bi = w[20:16]; r_aa = w[1];
    end else if (op == 6'd18) begin
      r_aa = w[1];
    end else if (op inside {6'd14, 6'd15, 6'd28, 6'd24, 6'd26, 6'd32, 6'd34,
                            6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44}) begin
      r_si = w[15:0];
    end else if (op == 6'd58 || op == 6'd62) begin
      r_ds = w[15:2]; r_xods = w[1:0];
    end
    return {op, w[25:21], w[20:16], w[15:11], r_bo, r_bi, r_si, r_ds, r_xods,
            r_xox, r_xoxo, r_aa, pc};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(output bit to);
    int n = 0;
    while (imem_req_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    to = (imem_req_valid !== 1'b1);
  endtask

  // Zero-wait memory transaction: accept the request, answer in the next cycle.
  task automatic serve(input logic [31:0] word, input logic [63:0] exp_pc, input bit push,
                       output logic [63:0] addr, output time t_req, output bit to);
    wait_req(to);
    addr  = imem_addr;
    t_req = $time;
    if (!to) begin
      imem_req_ready = 1'b1;
      tick();
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word;
      if (push) sb_q.push_back(ref_decode(word, exp_pc));
      tick();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'hDEAD_BEEF;
    end
  endtask

  // Wait for dec_valid, capture the fields, complete the handshake.
  task automatic accept(input bit br_same, output logic [146:0] got, output bit to);
    int n = 0;
    while (dec_valid !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    to  = (dec_valid !== 1'b1);
    got = obs;
    dec_ready = 1'b1;
    br_valid  = br_same;
    br_taken  = br_same;
    tick();
    dec_ready = 1'b0;
    br_valid  = 1'b0;
    br_taken  = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0 || imem_addr !== 64'h100 ||
        obs !== 147'd0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: req=%b dv=%b addr=%h fields=%h ill=%b, expected 0 0 100 0 0",
               imem_req_valid, dec_valid, imem_addr, obs, illegal);
    end
    rst = 1'b0;
  endtask

  task automatic test_decode_formats();
    logic [63:0] exp_pc, addr;
    logic [146:0] got, exp;
    time t, t_prev;
    bit to;
    exp_pc = 64'h100;
    t_prev = 0;
    for (int i = 0; i < 6; i++) begin
      serve(FMT_WORDS[i], exp_pc, 1'b1, addr, t, to);
      checks++;
      if (to || addr !== exp_pc) begin
        errors++;
        $display("FAIL fmt_addr[%0d]: got %h (timeout=%0d), expected %h", i, addr, to, exp_pc);
      end
      if (i > 0) begin
        checks++;
        if (t - t_prev != 30) begin
          errors++;
          $display("FAIL throughput[%0d]: request spacing %0t, expected 30", i, t - t_prev);
        end
      end
      t_prev = t;
      accept(1'b0, got, to);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 147'd0;
      checks++;
      if (to || got !== exp) begin
        errors++;
        $display("FAIL fmt_fields[%0d]: got %h (timeout=%0d), expected %h", i, got, to, exp);
      end
      if (i == 0) begin
        checks++;
        if ({opcode, rd, ra, rb, xoxo, xox, si} !== {6'd31, 5'd3, 5'd4, 5'd5, 9'd266, 10'd0, 16'd0}) begin
          errors++;
          $display("FAIL add_fields: got op=%0d rd=%0d ra=%0d rb=%0d xoxo=%0d xox=%0d si=%0d, expected 31 3 4 5 266 0 0",
                   opcode, rd, ra, rb, xoxo, xox, si);
        end
      end
      if (i == 1) begin
        checks++;
        if (xox !== 10'd28 || xoxo !== 9'd0) begin
          errors++;
          $display("FAIL and_fields: got xox=%0d xoxo=%0d, expected 28 0", xox, xoxo);
        end
      end
      if (i == 2) begin
        checks++;
        if ({opcode, rd, ra, si, ds, xox} !== {6'd14, 5'd3, 5'd1, 16'd100, 14'd0, 10'd0}) begin
          errors++;
          $display("FAIL addi_fields: got op=%0d rd=%0d ra=%0d si=%0d ds=%0d xox=%0d, expected 14 3 1 100 0 0",
                   opcode, rd, ra, si, ds, xox);
        end
      end
      exp_pc = exp_pc + 64'd4;
    end
  endtask

  task automatic test_branch_i();
    logic [63:0] addr;
    logic [146:0] got, exp;
    time t;
    bit to;
    for (int i = 0; i < 6; i++) begin
      serve(BR_WORDS[i], BR_PCS[i], 1'b1, addr, t, to);
      checks++;
      if (to || addr !== BR_PCS[i]) begin
        errors++;
        $display("FAIL jump_addr[%0d]: got %h (timeout=%0d), expected %h", i, addr, to, BR_PCS[i]);
      end
      accept(1'b0, got, to);
      exp = (sb_q.size() > 0) ? sb_q.pop_front() : 147'd0;
      checks++;
      if (to || got !== exp) begin
        errors++;
        $display("FAIL jump_fields[%0d]: got %h (timeout=%0d), expected %h", i, got, to, exp);
      end
    end
  endtask

  task automatic test_branch_b();
    logic [63:0] addr;
    logic [146:0] got, exp;
    time t;
    bit to;
    // Taken branch; resolution asserted during the handshake must be ignored.
    serve(32'h4C000012, 64'h300, 1'b1, addr, t, to);
    checks++;
    if (to || addr !== 64'h300) begin
      errors++;
      $display("FAIL bform_addr: got %h (timeout=%0d), expected 300", addr, to);
    end
    accept(1'b1, got, to);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 147'd0;
    checks++;
    if (to || got !== exp || exp[64] !== 1'b1 || exp[63:0] !== 64'h300) begin
      errors++;
      $display("FAIL bform_fields: got %h (timeout=%0d), expected %h with aa=1 dec_pc=300", got, to, exp);
    end
    for (int k = 0; k < 3; k++) begin
      imem_rsp_valid = 1'b1;
      tick();
      checks++;
      if (imem_req_valid !== 1'b0 || dec_valid !== 1'b0) begin
        errors++;
        $display("FAIL wait_br_idle[%0d]: got req=%b dv=%b, expected 0 0", k, imem_req_valid, dec_valid);
      end
    end
    imem_rsp_valid = 1'b0;
    br_valid = 1'b1;
    br_taken = 1'b1;
    tick();
    br_valid = 1'b0;
    br_taken = 1'b0;
    serve(32'h48000302, 64'h310, 1'b1, addr, t, to);
    checks++;
    if (to || addr !== 64'h310) begin
      errors++;
      $display("FAIL br_taken_addr: got %h (timeout=%0d), expected 310", addr, to);
    end
    accept(1'b0, got, to);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 147'd0;
    checks++;
    if (to || got !== exp) begin
      errors++;
      $display("FAIL return_fields: got %h (timeout=%0d), expected %h", got, to, exp);
    end
    // Not-taken branch.
    serve(32'h4C000012, 64'h300, 1'b1, addr, t, to);
    accept(1'b0, got, to);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 147'd0;
    checks++;
    if (to || got !== exp) begin
      errors++;
      $display("FAIL bform2_fields: got %h (timeout=%0d), expected %h", got, to, exp);
    end
    br_valid = 1'b1;
    br_taken = 1'b0;
    tick();
    br_valid = 1'b0;
    wait_req(to);
    checks++;
    if (to || imem_addr !== 64'h304) begin
      errors++;
      $display("FAIL br_not_taken_addr: got %h (timeout=%0d), expected 304", imem_addr, to);
    end
  endtask

  task automatic test_stall();
    logic [146:0] got, exp;
    bit to;
    wait_req(to);
    checks++;
    if (to || imem_addr !== 64'h304) begin
      errors++;
      $display("FAIL stall_addr: got %h (timeout=%0d), expected 304", imem_addr, to);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (imem_req_valid !== 1'b1 || imem_addr !== 64'h304 || dec_valid !== 1'b0) begin
        errors++;
        $display("FAIL req_stable[%0d]: got req=%b addr=%h dv=%b, expected 1 304 0",
                 k, imem_req_valid, imem_addr, dec_valid);
      end
    end
    // A response in the acceptance cycle must be dropped.
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h0000_0000;
    tick();
    imem_req_ready = 1'b0;
    imem_rsp_data  = 32'h7C642A14;
    sb_q.push_back(ref_decode(32'h7C642A14, 64'h304));
    tick();
    imem_rsp_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (dec_valid !== 1'b1 || imem_req_valid !== 1'b0 || obs !== sb_q[0] || illegal !== 1'b0) begin
        errors++;
        $display("FAIL out_stable[%0d]: got dv=%b req=%b ill=%b fields=%h, expected 1 0 0 %h",
                 k, dec_valid, imem_req_valid, illegal, obs, sb_q[0]);
      end
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = 32'h0000_0000;
      tick();
    end
    imem_rsp_valid = 1'b0;
    accept(1'b0, got, to);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 147'd0;
    checks++;
    if (to || got !== exp) begin
      errors++;
      $display("FAIL stall_fields: got %h (timeout=%0d), expected %h", got, to, exp);
    end
  endtask

  task automatic test_illegal();
    logic [63:0] addr;
    time t;
    bit to;
    serve(32'h0000_0000, 64'h308, 1'b0, addr, t, to);
    checks++;
    if (to || addr !== 64'h308) begin
      errors++;
      $display("FAIL illegal_addr: got %h (timeout=%0d), expected 308", addr, to);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0 || illegal !== 1'b1) begin
        errors++;
        $display("FAIL halt_state[%0d]: got dv=%b req=%b ill=%b, expected 0 0 1",
                 k, dec_valid, imem_req_valid, illegal);
      end
      tick();
    end
    rst = 1'b1;
    tick();
    checks++;
    if (illegal !== 1'b0 || imem_req_valid !== 1'b0 || dec_valid !== 1'b0 || imem_addr !== 64'h100) begin
      errors++;
      $display("FAIL halt_reset: got ill=%b req=%b dv=%b addr=%h, expected 0 0 0 100",
               illegal, imem_req_valid, dec_valid, imem_addr);
    end
    rst = 1'b0;
  endtask

  task automatic test_reset_midflight();
    logic [63:0] addr;
    logic [146:0] got, exp;
    time t;
    bit to;
    wait_req(to);
    checks++;
    if (to || imem_addr !== 64'h100) begin
      errors++;
      $display("FAIL restart_addr: got %h (timeout=%0d), expected 100", imem_addr, to);
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h7C642A14;
    tick();
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    checks++;
    if (dec_valid !== 1'b0 || imem_req_valid !== 1'b0 || imem_addr !== 64'h100 || obs !== 147'd0) begin
      errors++;
      $display("FAIL reset_wins: got dv=%b req=%b addr=%h fields=%h, expected 0 0 100 0",
               dec_valid, imem_req_valid, imem_addr, obs);
    end
    serve(32'h38610064, 64'h100, 1'b1, addr, t, to);
    checks++;
    if (to || addr !== 64'h100) begin
      errors++;
      $display("FAIL post_reset_addr: got %h (timeout=%0d), expected 100", addr, to);
    end
    accept(1'b0, got, to);
    exp = (sb_q.size() > 0) ? sb_q.pop_front() : 147'd0;
    checks++;
    if (to || got !== exp) begin
      errors++;
      $display("FAIL post_reset_fields: got %h (timeout=%0d), expected %h", got, to, exp);
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end
  endtask

  initial begin
    rst            = 1'b1;
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'h0;
    dec_ready      = 1'b0;
    br_valid       = 1'b0;
    br_taken       = 1'b0;
    test_reset();
    test_decode_formats();
    test_branch_i();
    test_branch_b();
    test_stall();
    test_illegal();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1);
  end

endmodule
